// File: rtl/fetch_unit_if.sv
// Decoder-side handshake of the LIPSI fetch stage: one assembled instruction per valid/ready
// transfer.
interface fetch_unit_if;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr_opcode;
    logic [7:0] instr_operand;
    logic [7:0] instr_pc;

    modport master (
        output instr_valid,
        output instr_opcode,
        output instr_operand,
        output instr_pc,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr_opcode,
        input  instr_operand,
        input  instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// LIPSI instruction fetch: assembles 1/2-byte instructions from synchronous imem for the decoder.
// Define FETCH_OVERLAP_EN to start the next opcode fetch in the same cycle as a transfer.
module fetch_unit #(
    parameter logic [2:0] TWO_BYTE_PREFIX = 3'b110,
    parameter logic [7:0] EXIT_OPCODE     = 8'hFF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   pc_in,
    output logic         pc_inc,
    output logic         pc_load,
    output logic [7:0]   pc_load_value,
    output logic [7:0]   imem_addr,
    input  logic [7:0]   imem_rdata,
    input  logic         redirect,
    input  logic [7:0]   redirect_target,
    output logic         halted,
    fetch_unit_if.master dec_if
);

    typedef enum logic [2:0] {
        StRst,
        StOpAddr,
        StOpData,
        StArgData,
        StHold,
        StHalt
    } state_e;

    state_e     r_state;
    logic [7:0] r_opcode;
    logic [7:0] r_operand;
    logic [7:0] r_pc;
    logic       r_halted;

    logic w_two_byte;
    logic w_xfer;
    logic w_overlap;

    assign imem_addr     = pc_in;
    assign pc_load_value = redirect_target;

    assign w_two_byte = (imem_rdata[7:5] == TWO_BYTE_PREFIX);

    // A redirect in the same cycle suppresses the handshake, so ready alone is not a transfer.
    assign dec_if.instr_valid = (r_state == StHold) && !redirect;
    assign w_xfer             = dec_if.instr_valid && dec_if.instr_ready;

`ifdef FETCH_OVERLAP_EN
    assign w_overlap = w_xfer && (r_opcode != EXIT_OPCODE);
`else
    assign w_overlap = 1'b0;
`endif

    assign dec_if.instr_opcode  = r_opcode;
    assign dec_if.instr_operand = r_operand;
    assign dec_if.instr_pc      = r_pc;
    assign halted               = r_halted;

    always_comb begin
        pc_inc  = 1'b0;
        pc_load = 1'b0;
        if (r_state != StRst) begin
            if (redirect) begin
                pc_load = 1'b1;
            end else begin
                case (r_state)
                    StOpAddr: pc_inc = 1'b1;
                    StOpData: pc_inc = w_two_byte;
                    StHold:   pc_inc = w_overlap;
                    default:  pc_inc = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= StRst;
            r_opcode  <= 8'h00;
            r_operand <= 8'h00;
            r_pc      <= 8'h00;
            r_halted  <= 1'b0;
        end else if (redirect && (r_state != StRst)) begin
            // Any partially assembled instruction is simply abandoned.
            r_state  <= StOpAddr;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                StRst: r_state <= StOpAddr;
                StOpAddr: begin
                    r_pc    <= pc_in;
                    r_state <= StOpData;
                end
                StOpData: begin
                    r_opcode <= imem_rdata;
                    if (w_two_byte) begin
                        r_state <= StArgData;
                    end else begin
                        r_operand <= 8'h00;
                        r_state   <= StHold;
                    end
                end
                StArgData: begin
                    r_operand <= imem_rdata;
                    r_state   <= StHold;
                end
                StHold: begin
                    if (w_xfer) begin
                        if (r_opcode == EXIT_OPCODE) begin
                            r_state  <= StHalt;
                            r_halted <= 1'b1;
                        end else if (w_overlap) begin
                            r_pc    <= pc_in;
                            r_state <= StOpData;
                        end else begin
                            r_state <= StOpAddr;
                        end
                    end
                end
                StHalt:  r_state <= StHalt;
                default: r_state <= StRst;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: PC + imem environment, instruction-stream scoreboard,
// directed scenarios and a randomized ready/redirect run.
module tb_fetch_unit;
    localparam logic [2:0] Prefix = 3'b110;
    localparam logic [7:0] ExitOp = 8'hFF;
`ifdef FETCH_OVERLAP_EN
    localparam int Gap1 = 2;
    localparam int Gap2 = 3;
`else
    localparam int Gap1 = 3;
    localparam int Gap2 = 4;
`endif

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] pc_in;
    logic [7:0] imem_addr;
    logic [7:0] imem_rdata;
    logic [7:0] pc_load_value;
    logic [7:0] redirect_target;
    logic       pc_inc;
    logic       pc_load;
    logic       redirect;
    logic       halted;

    fetch_unit_if dec_if ();

    fetch_unit #(
        .TWO_BYTE_PREFIX(Prefix),
        .EXIT_OPCODE    (ExitOp)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_in          (pc_in),
        .pc_inc         (pc_inc),
        .pc_load        (pc_load),
        .pc_load_value  (pc_load_value),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect       (redirect),
        .redirect_target(redirect_target),
        .halted         (halted),
        .dec_if         (dec_if)
    );

    always #5 clk = ~clk;

    // Environment: program counter and synchronous instruction memory.
    logic [7:0] mem [256];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_in      <= 8'h00;
            imem_rdata <= 8'h00;
        end else begin
            imem_rdata <= mem[imem_addr];
            if (pc_load)     pc_in <= pc_load_value;
            else if (pc_inc) pc_in <= pc_in + 8'd1;
        end
    end

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int xfer_cnt = 0;
    int xfer_gap = 0;
    int last_xfer_cyc = 0;
    int first_valid_cyc = -1;
    int n_inc = 0;
    logic [7:0] exp_pc = 8'h00;
    logic [7:0] last_xfer_pc = 8'h00;
    logic [7:0] last_xfer_opnd = 8'h00;
    logic [7:0] prev_op, prev_opnd, prev_pc;
    bit exp_halt = 1'b0;
    bit in_rst = 1'b0;
    bit stall_prev = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One cycle: sample just after the negedge drive, score, then advance to the next negedge.
    task automatic tick();
        logic [7:0] op, opnd, a1, nxt;
        #1;
        if (reset) begin
            exp_pc     = 8'h00;
            exp_halt   = 1'b0;
            in_rst     = 1'b1;
            stall_prev = 1'b0;
        end else if (in_rst) begin
            check_eq("rst_state_ctl", {dec_if.instr_valid, pc_inc, pc_load, halted}, 4'b0);
            in_rst = 1'b0;
        end else begin
            if (pc_inc) n_inc++;
            if (dec_if.instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            check_eq("halted", halted, exp_halt);
            check_eq("load_eq_redirect", pc_load, redirect);
            check_eq("inc_load_excl", pc_inc & pc_load, 1'b0);
            if (exp_halt && !redirect) check_eq("halt_no_inc", pc_inc, 1'b0);
            if (stall_prev) begin
                check_eq("stall_hold",
                         {dec_if.instr_opcode, dec_if.instr_operand, dec_if.instr_pc},
                         {prev_op, prev_opnd, prev_pc});
                check_eq("stall_valid", dec_if.instr_valid, !redirect);
            end
            stall_prev = 1'b0;
            if (redirect) begin
                check_eq("valid_gated", dec_if.instr_valid, 1'b0);
                exp_pc   = redirect_target;
                exp_halt = 1'b0;
            end else if (dec_if.instr_valid && dec_if.instr_ready) begin
                a1   = exp_pc + 8'd1;
                op   = mem[exp_pc];
                opnd = (op[7:5] == Prefix) ? mem[a1] : 8'h00;
                nxt  = (op[7:5] == Prefix) ? exp_pc + 8'd2 : a1;
                check_eq("xfer_pc", dec_if.instr_pc, exp_pc);
                check_eq("xfer_opcode", dec_if.instr_opcode, op);
                check_eq("xfer_operand", dec_if.instr_operand, opnd);
                check_eq("pc_after", pc_in, nxt);
                xfer_gap       = cyc - last_xfer_cyc;
                last_xfer_cyc  = cyc;
                last_xfer_pc   = dec_if.instr_pc;
                last_xfer_opnd = dec_if.instr_operand;
                xfer_cnt++;
                exp_pc = nxt;
                if (op == ExitOp) exp_halt = 1'b1;
            end else if (dec_if.instr_valid) begin
                stall_prev = 1'b1;
                prev_op    = dec_if.instr_opcode;
                prev_opnd  = dec_if.instr_operand;
                prev_pc    = dec_if.instr_pc;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        redirect        = 1'b0;
        redirect_target = 8'h00;
        tick();
        tick();
        check_eq("reset_outs",
                 {pc_inc, pc_load, imem_addr, pc_load_value, dec_if.instr_valid,
                  dec_if.instr_opcode, dec_if.instr_operand, dec_if.instr_pc, halted}, 44'h0);
        reset           = 1'b0;
        first_valid_cyc = -1;
    endtask

    task automatic run_xfers(input int n, input int max_cyc);
        int x0;
        x0 = xfer_cnt;
        for (int i = 0; i < max_cyc && (xfer_cnt - x0) < n; i++) tick();
        check_eq("xfer_timeout", xfer_cnt - x0, n);
    endtask

    task automatic wait_valid(input int max_cyc);
        for (int i = 0; i < max_cyc && first_valid_cyc < 0; i++) tick();
        check_eq("valid_timeout", first_valid_cyc >= 0, 1'b1);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    initial begin
        int rel, n_mark, i0, x0;
        logic [7:0] pc0;
        dec_if.instr_ready = 1'b0;
        redirect           = 1'b0;
        redirect_target    = 8'h00;
        clear_mem();
        @(negedge clk);

        // Back-to-back 1-byte instructions: latency and throughput.
        mem[0] = 8'h12;
        mem[1] = 8'h23;
        dec_if.instr_ready = 1'b1;
        do_reset();
        rel = cyc;
        run_xfers(2, 20);
        check_eq("first_latency", first_valid_cyc - rel, 3);
        check_eq("gap_1byte", xfer_gap, Gap1);
        check_eq("second_pc", last_xfer_pc, 8'h01);

        // 2-byte instructions.
        clear_mem();
        mem[0] = 8'hC5;
        mem[1] = 8'h7A;
        mem[2] = 8'hC0;
        mem[3] = 8'h11;
        do_reset();
        run_xfers(1, 20);
        check_eq("2b_operand", last_xfer_opnd, 8'h7A);
        run_xfers(1, 20);
        check_eq("gap_2byte", xfer_gap, Gap2);
        check_eq("2b_next_pc", last_xfer_pc, 8'h02);

        // Decoder stall.
        clear_mem();
        mem[0] = 8'h12;
        dec_if.instr_ready = 1'b0;
        do_reset();
        wait_valid(10);
        pc0 = pc_in;
        i0  = n_inc;
        repeat (5) tick();
        check_eq("stall_pc_in", pc_in, pc0);
        check_eq("stall_no_inc", n_inc - i0, 0);
        x0 = xfer_cnt;
        dec_if.instr_ready = 1'b1;
        tick();
        dec_if.instr_ready = 1'b0;
        repeat (3) tick();
        check_eq("stall_one_xfer", xfer_cnt - x0, 1);

        // Redirect while the operand byte is in flight.
        clear_mem();
        mem[0]    = 8'hC5;
        mem[1]    = 8'h7A;
        mem[8'h40] = 8'h33;
        dec_if.instr_ready = 1'b1;
        do_reset();
        repeat (3) tick();
        redirect        = 1'b1;
        redirect_target = 8'h40;
        n_mark          = cyc;
        first_valid_cyc = -1;
        tick();
        redirect = 1'b0;
        wait_valid(10);
        check_eq("redir_latency", first_valid_cyc - n_mark, 3);
        check_eq("redir_pc", last_xfer_pc, 8'h40);

        // 2-byte instruction straddling the address wrap.
        clear_mem();
        mem[8'hFF] = 8'hC3;
        mem[0]     = 8'h5A;
        do_reset();
        tick();
        redirect        = 1'b1;
        redirect_target = 8'hFF;
        tick();
        redirect = 1'b0;
        run_xfers(1, 20);
        check_eq("wrap_pc", last_xfer_pc, 8'hFF);
        check_eq("wrap_operand", last_xfer_opnd, 8'h5A);
        run_xfers(1, 20);
        check_eq("wrap_next_pc", last_xfer_pc, 8'h01);

        // Exit opcode, halt, resume by redirect, then reset mid-fetch.
        clear_mem();
        for (int i = 0; i < 5; i++) mem[i] = 8'h01;
        mem[5] = ExitOp;
        do_reset();
        for (int i = 0; i < 60 && !halted; i++) tick();
        check_eq("halt_reach", halted, 1'b1);
        check_eq("halt_pc_in", pc_in, 8'h06);
        repeat (10) tick();
        check_eq("halt_pc_stays", pc_in, 8'h06);
        redirect        = 1'b1;
        redirect_target = 8'h00;
        tick();
        redirect = 1'b0;
        check_eq("halt_clear", halted, 1'b0);
        run_xfers(1, 10);
        check_eq("resume_pc", last_xfer_pc, 8'h00);
`ifndef FETCH_OVERLAP_EN
        tick();
`endif
        reset = 1'b1;
        #1;
        check_eq("reset_mid",
                 {pc_inc, pc_load, imem_addr, pc_load_value, dec_if.instr_valid,
                  dec_if.instr_opcode, dec_if.instr_operand, dec_if.instr_pc, halted}, 44'h0);
        tick();
        reset = 1'b0;

        // Randomized program, ready and redirects against the stream model.
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        repeat (4) mem[8'($urandom)] = ExitOp;
        dec_if.instr_ready = 1'b1;
        do_reset();
        tick();
        for (int i = 0; i < 3000; i++) begin
            dec_if.instr_ready = ($urandom_range(0, 99) < 70);
            if (redirect) redirect = 1'b0;
            else redirect = ($urandom_range(0, 99) < (halted ? 25 : 3));
            redirect_target = 8'($urandom);
            tick();
        end
        redirect = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the LIPSI processor, directly downstream of the program counter. Each cycle it reads `pc_out`, drives the PC's `inc`/`load` controls, and reads one byte per cycle from synchronous instruction memory. It assembles 1- or 2-byte instructions and presents them to the decoder with a valid/ready handshake. Branch redirects and the exit instruction are handled here.

## Interface
Parameters:
- `TWO_BYTE_PREFIX`, default 3'b110. Opcodes whose bits [7:5] equal this value carry a second byte (immediate or branch target).
- `EXIT_OPCODE`, default 8'hFF. After this opcode is delivered, fetching stops.

Ports:
- `clk`, in, 1: clock. All state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `pc_in`, in, 8: current PC (`pc_out` of the PC block).
- `pc_inc`, out, 1: PC increment request.
- `pc_load`, out, 1: PC load request.
- `pc_load_value`, out, 8: value loaded into the PC.
- `imem_addr`, out, 8: instruction memory address. Memory registers it; data returns on `imem_rdata` the next cycle.
- `imem_rdata`, in, 8: instruction memory read data.
- `redirect`, in, 1: taken branch or jump from execute. Single-cycle pulse.
- `redirect_target`, in, 8: new PC for the redirect.
- `instr_valid`, out, 1: an assembled instruction is held for the decoder.
- `instr_ready`, in, 1: the decoder accepts the instruction.
- `instr_opcode`, out, 8: first byte of the instruction.
- `instr_operand`, out, 8: second byte; 8'h00 for 1-byte instructions.
- `instr_pc`, out, 8: address of the opcode byte.
- `halted`, out, 1: the exit opcode has been delivered and fetch is stopped.

## Operation
States: S_RST, S_OP_ADDR, S_OP_DATA, S_ARG_DATA, S_HOLD, S_HALT.

- `imem_addr` = `pc_in` at all times. `pc_load_value` = `redirect_target` at all times.
- **S_RST** (reset state): all outputs 0. Unconditionally goes to S_OP_ADDR.
- **S_OP_ADDR**: assert `pc_inc`; register `instr_pc` <= `pc_in`. Go to S_OP_DATA.
- **S_OP_DATA**: register `instr_opcode` <= `imem_rdata`.
  - If `imem_rdata[7:5]` == `TWO_BYTE_PREFIX`: assert `pc_inc` and go to S_ARG_DATA.
  - Otherwise: `instr_operand` <= 0 and go to S_HOLD.
- **S_ARG_DATA**: register `instr_operand` <= `imem_rdata`. Go to S_HOLD.
- **S_HOLD**: `instr_valid` = 1 while `redirect` = 0. Transfer occurs when `instr_valid` & `instr_ready`. On transfer:
  - opcode == `EXIT_OPCODE`: go to S_HALT.
  - otherwise: go to S_OP_ADDR.
  - With no transfer, all instr_* outputs hold stable.
- **S_HALT**: `halted` = 1, no `pc_inc`, no memory progress. Leaves only on `redirect` or `reset`.
- **Redirect**, in any state except S_RST:
  - `pc_load` = 1 and `pc_inc` is forced to 0; load wins.
  - Any partially assembled instruction is discarded. `instr_valid` is gated low in the same cycle; a simultaneous `instr_ready` is not a transfer.
  - `halted` clears. Next state is S_OP_ADDR.
- Reset mid-operation: immediately returns to S_RST with all outputs 0. The in-flight byte is lost.
- PC arithmetic is 8-bit and wraps: 8'hFF + 1 = 8'h00. A 2-byte instruction at 8'hFF takes its operand from 8'h00.

## Timing
- Reset values: every output 0, state S_RST.
- After reset deasserts at edge E0:
  - edge E1: S_OP_ADDR
  - edge E2: S_OP_DATA
  - after edge E3: `instr_valid` high for a 1-byte instruction.
  - after edge E4: `instr_valid` high for a 2-byte instruction.
- Steady-state throughput with `instr_ready` held high: one 1-byte instruction per 3 cycles, one 2-byte instruction per 4 cycles.
- Redirect latency: redirect in cycle N, S_OP_ADDR in cycle N+1, first redirected instruction valid in cycle N+3 (1-byte).
- `pc_inc` and `pc_load` are combinational from state and `redirect`; they are never both high.

## Configuration
- `FETCH_OVERLAP_EN` defined: on a non-exit transfer in S_HOLD, the unit also performs the S_OP_ADDR actions in that same cycle. It asserts `pc_inc`, registers `instr_pc` <= `pc_in`, and goes directly to S_OP_DATA. Throughput becomes 2 cycles per 1-byte and 3 cycles per 2-byte instruction. Redirect behaviour is unchanged and still takes priority.
- `FETCH_OVERLAP_EN` undefined: behaviour exactly as in Operation.

## Test plan
- Reset, then memory 00:8'h12, 01:8'h23, `instr_ready`=1 -> valid after edge 3: opcode 12, operand 00, `instr_pc` 00. Next: opcode 23, `instr_pc` 01. `pc_inc` pulses once per instruction.
- Memory 00:8'hC5, 01:8'h7A, 02:8'h01 -> opcode C5, operand 7A, `instr_pc` 00. Next instruction at `instr_pc` 02.
- `instr_ready`=0 for 5 cycles while holding opcode 12 -> outputs stable, no `pc_inc`, `pc_in` unchanged. Then `instr_ready`=1 -> exactly one transfer.
- `redirect`=1 with `redirect_target`=8'h40 while in S_ARG_DATA -> `pc_load`=1, `pc_inc`=0, partial instruction dropped. Next valid `instr_pc` is 40.
- Memory 05:8'hFF is delivered -> `halted`=1 and `pc_in` stays 06 for 10 cycles. Then `redirect` to 8'h00 -> `halted`=0 and fetch resumes at 00.
- Reset asserted in S_OP_DATA -> all outputs 0 immediately. With `FETCH_OVERLAP_EN` defined, back-to-back 1-byte instructions transfer every 2 cycles.
